cla_sub_pipe_64: RTL and testbench

//   Pipelined 64-bit subtractor. Computes diff = a - b - bin.

---
 rtl/cla_sub_pipe_64_if.sv | 26 ++
 rtl/cla_sub_pipe_64.sv | 111 +++++++++++
 tb/tb_cla_sub_pipe_64.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_sub_pipe_64_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// master = operand producer and result consumer; slave = the subtractor.
interface cla_sub_pipe_64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/cla_sub_pipe_64.sv
// Pipelined a - b - bin built from SLICE-bit carry-lookahead slices, one slice per stage.
// Latency: STAGES clock edges counting the accepting edge; one result per cycle.
// Backpressure: global stall, in_ready = !out_valid || out_ready; every stage holds when stalled.
module cla_sub_pipe_64 #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_sub_pipe_64_if.slave      bus
);
    localparam int STAGES = WIDTH / SLICE;

    typedef struct packed {
        logic             vld;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
    } stage_t;

    // Flat lookahead form: each carry is a sum of generate terms masked by propagate runs.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             cin
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        logic             cc;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            cc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & cin);
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    stage_t           stage_q [STAGES-1];
    stage_t           stage_d [STAGES-1];
    logic [SLICE:0]   res     [STAGES];
    logic [WIDTH-1:0] diff_d;
    logic             ovf_d;
    logic             out_vld_q;
    logic             bout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] diff_q;
    logic             advance;

    assign advance       = !out_vld_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_vld_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        // Subtraction as a + ~b with carry-in ~bin; the final carry is the inverted borrow.
        res[0]     = cla_slice(bus.a[SLICE-1:0], ~bus.b[SLICE-1:0], ~bus.bin);
        stage_d[0] = '{vld:  bus.in_valid,
                       c:    res[0][SLICE],
                       a:    bus.a,
                       b:    bus.b,
                       diff: {{(WIDTH-SLICE){1'b0}}, res[0][SLICE-1:0]}};
        for (int k = 1; k < STAGES - 1; k++) begin
            res[k]     = cla_slice(stage_q[k-1].a[k*SLICE +: SLICE],
                                   ~stage_q[k-1].b[k*SLICE +: SLICE],
                                   stage_q[k-1].c);
            stage_d[k]                        = stage_q[k-1];
            stage_d[k].c                      = res[k][SLICE];
            stage_d[k].diff[k*SLICE +: SLICE] = res[k][SLICE-1:0];
        end
        res[STAGES-1] = cla_slice(stage_q[STAGES-2].a[WIDTH-SLICE +: SLICE],
                                  ~stage_q[STAGES-2].b[WIDTH-SLICE +: SLICE],
                                  stage_q[STAGES-2].c);
        diff_d                        = stage_q[STAGES-2].diff;
        diff_d[WIDTH-SLICE +: SLICE]  = res[STAGES-1][SLICE-1:0];
        ovf_d = (stage_q[STAGES-2].a[WIDTH-1] != stage_q[STAGES-2].b[WIDTH-1]) &&
                (diff_d[WIDTH-1] != stage_q[STAGES-2].a[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                stage_q[k] <= '0;
            end
            out_vld_q <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                stage_q[k] <= stage_d[k];
            end
            out_vld_q <= stage_q[STAGES-2].vld;
            diff_q    <= diff_d;
            bout_q    <= ~res[STAGES-1][SLICE];
            ovf_q     <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_sub_pipe_64.sv
// Scoreboard bench for cla_sub_pipe_64: directed corner cases, stall, reset and random traffic.
module tb_cla_sub_pipe_64;
    typedef struct packed {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   n_pop  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cla_sub_pipe_64_if #(.WIDTH(64)) bus ();

    cla_sub_pipe_64 #(.WIDTH(64), .SLICE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    endtask

    // Reference: unsigned wide subtraction for diff/borrow, signed range test for overflow.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
        logic [64:0]        u;
        logic signed [65:0] s;
        exp_t               e;
        u = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bin});
        e.diff = u[63:0];
        e.bout = u[64];
        e.ovf  = (s < -(66'sd1 <<< 63)) || (s > ((66'sd1 <<< 63) - 66'sd1));
        return e;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply(input logic v, input logic [63:0] av, input logic [63:0] bv,
                         input logic bn, input logic ordy, output logic acc);
        bus.in_valid  = v;
        bus.a         = av;
        bus.b         = bv;
        bus.bin       = bn;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
    endtask

    // Monitor: a result is consumed on the edge following a cycle with out_valid && out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_pop++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 65'd1, 65'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("diff", {1'b0, bus.diff}, {1'b0, e.diff});
                    chk("bout", {64'd0, bus.bout}, {64'd0, e.bout});
                    chk("ovf",  {64'd0, bus.ovf},  {64'd0, e.ovf});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          lat;
        int          sent;
        int          stall_cnt;
        int          seen;
        int          n_acc;
        int          cyc;
        logic        ordy;
        logic [63:0] held;
        logic [63:0] da [5];
        logic [63:0] db [5];
        logic        dbin [5];
        exp_t        dexp [5];
        logic [63:0] sa [6];
        logic [63:0] sbv [6];
        logic        sbin [6];

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) tick();
        #1;
        chk("rst_out_valid", {64'd0, bus.out_valid}, 65'd0);
        chk("rst_in_ready",  {64'd0, bus.in_ready},  65'd1);
        chk("rst_diff",      {1'b0, bus.diff},       65'd0);
        chk("rst_bout_ovf",  {63'd0, bus.bout, bus.ovf}, 65'd0);
        tick();
        rst = 1'b0;

        // 5 - 3: latency and single-cycle valid pulse
        tick();
        apply(1'b1, 64'd5, 64'd3, 1'b0, 1'b1, acc);
        chk("t1_accept", {64'd0, acc}, 65'd1);
        if (acc) sb_q.push_back('{diff: 64'd2, bout: 1'b0, ovf: 1'b0});
        lat = 0;
        do begin
            tick();
            apply(1'b0, '0, '0, 1'b0, 1'b1, acc);
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk("t1_latency", 65'(lat), 65'd4);
        tick();
        apply(1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("t1_valid_one_cycle", {64'd0, bus.out_valid}, 65'd0);

        // corner operands, issued back to back
        da[0] = 64'd0;                   db[0] = 64'd1;          dbin[0] = 1'b0;
        dexp[0] = '{diff: 64'hFFFF_FFFF_FFFF_FFFF, bout: 1'b1, ovf: 1'b0};
        da[1] = 64'h8000_0000_0000_0000; db[1] = 64'd1;          dbin[1] = 1'b0;
        dexp[1] = '{diff: 64'h7FFF_FFFF_FFFF_FFFF, bout: 1'b0, ovf: 1'b1};
        da[2] = 64'h0001_0000_0000_0000; db[2] = 64'd0;          dbin[2] = 1'b1;
        dexp[2] = '{diff: 64'h0000_FFFF_FFFF_FFFF, bout: 1'b0, ovf: 1'b0};
        da[3] = 64'h1234_5678_9ABC_DEF0; db[3] = 64'h1234_5678_9ABC_DEF0; dbin[3] = 1'b0;
        dexp[3] = '{diff: 64'd0, bout: 1'b0, ovf: 1'b0};
        da[4] = 64'h1234_5678_9ABC_DEF0; db[4] = 64'h1234_5678_9ABC_DEF0; dbin[4] = 1'b1;
        dexp[4] = '{diff: 64'hFFFF_FFFF_FFFF_FFFF, bout: 1'b1, ovf: 1'b0};
        for (int i = 0; i < 5; i++) begin
            tick();
            apply(1'b1, da[i], db[i], dbin[i], 1'b1, acc);
            if (acc) sb_q.push_back(dexp[i]);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            apply(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end
        chk("corner_drain", 65'(sb_q.size()), 65'd0);

        // stream of 6 with a 3-cycle consumer stall once results appear
        for (int i = 0; i < 6; i++) begin
            sa[i] = r64(); sbv[i] = r64(); sbin[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; stall_cnt = 0; cyc = 0; held = '0;
        n_pop = 0;
        while ((sent < 6 || sb_q.size() > 0) && cyc < 40) begin
            tick();
            ordy = 1'b1;
            if (stall_cnt < 3 && bus.out_valid) begin
                ordy = 1'b0;
                if (stall_cnt == 0) held = bus.diff;
                else chk("stall_diff_hold", {1'b0, bus.diff}, {1'b0, held});
                stall_cnt++;
            end
            if (sent < 6) apply(1'b1, sa[sent], sbv[sent], sbin[sent], ordy, acc);
            else          apply(1'b0, '0, '0, 1'b0, ordy, acc);
            if (!ordy) chk("stall_in_ready", {64'd0, bus.in_ready}, 65'd0);
            if (acc) begin
                sb_q.push_back(model(sa[sent], sbv[sent], sbin[sent]));
                sent++;
            end
            cyc++;
        end
        tick();
        chk("stream_sent", 65'(sent), 65'd6);
        chk("stream_results", 65'(n_pop), 65'd6);
        chk("stream_drain", 65'(sb_q.size()), 65'd0);

        // reset with three operations in flight and the first one stalled at the output
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, r64(), r64(), 1'b0, 1'b0, acc);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, '0, '0, 1'b0, 1'b0, acc);
            tick();
        end
        chk("pre_rst_out_valid", {64'd0, bus.out_valid}, 65'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {64'd0, bus.out_valid}, 65'd0);
        chk("async_rst_diff",      {1'b0, bus.diff},       65'd0);
        chk("async_rst_in_ready",  {64'd0, bus.in_ready},  65'd1);
        sb_q.delete();
        tick();
        #3;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            apply(1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (bus.out_valid) seen++;
        end
        chk("no_stale_after_rst", 65'(seen), 65'd0);
        tick();
        sa[0] = r64(); sbv[0] = r64();
        apply(1'b1, sa[0], sbv[0], 1'b1, 1'b1, acc);
        if (acc) sb_q.push_back(model(sa[0], sbv[0], 1'b1));
        lat = 0;
        do begin
            tick();
            apply(1'b0, '0, '0, 1'b0, 1'b1, acc);
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk("post_rst_latency", 65'(lat), 65'd4);

        // random traffic with random consumer backpressure
        n_acc = 0; cyc = 0;
        while (n_acc < 10000 && cyc < 40000) begin
            tick();
            sa[0]   = r64();
            sbv[0]  = ($urandom_range(0, 15) == 0) ? sa[0] : r64();
            sbin[0] = 1'($urandom_range(0, 1));
            apply(1'($urandom_range(0, 3) != 0), sa[0], sbv[0], sbin[0],
                  1'($urandom_range(0, 3) != 0), acc);
            if (acc) begin
                sb_q.push_back(model(sa[0], sbv[0], sbin[0]));
                n_acc++;
            end
            cyc++;
        end
        chk("random_accepted", 65'(n_acc), 65'd10000);
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 20) begin
            tick();
            apply(1'b0, '0, '0, 1'b0, 1'b1, acc);
            cyc++;
        end
        tick();
        chk("random_drain", 65'(sb_q.size()), 65'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
